// File: rtl/mem_stage.sv
// Memory pipeline stage: load extraction/merge, write-back handshake and decode bypass.
// Define MS_RDATA_HOLD_EN to buffer SRAM read data across write-back stalls.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 111,
   parameter int MS_TO_WS_BUS_WD = 70
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ms_valid,
   output logic                       ms_fwd_we,
   output logic [4:0]                 ms_fwd_dest,
   output logic [31:0]                ms_fwd_data
);

   logic                       ms_ready_go;
   logic                       ms_valid_q, ms_valid_d;
   logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;

   logic [31:0] rt_value;
   logic        res_from_mem;
   logic [1:0]  addr_low;
   logic        op_lb, op_lbu, op_lh, op_lhu, op_lwl, op_lwr;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic [31:0] rdata_use;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] load_result;
   logic [31:0] final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign ms_valid       = ms_valid_q;

   always_comb begin
      ms_valid_d = ms_valid_q;
      bus_d      = bus_q;
      if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
         bus_d = es_to_ms_bus;
      end
   end

   // Bus contents are don't-care while invalid, so only the valid flag is reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q <= 1'b0;
      end else begin
         ms_valid_q <= ms_valid_d;
      end
      bus_q <= bus_d;
   end

   assign rt_value     = bus_q[110:79];
   assign res_from_mem = bus_q[78];
   assign addr_low     = bus_q[77:76];
   assign op_lb        = bus_q[75];
   assign op_lbu       = bus_q[74];
   assign op_lh        = bus_q[73];
   assign op_lhu       = bus_q[72];
   assign op_lwl       = bus_q[71];
   assign op_lwr       = bus_q[70];
   assign gr_we        = bus_q[69];
   assign dest         = bus_q[68:64];
   assign alu_result   = bus_q[63:32];
   assign pc           = bus_q[31:0];

`ifdef MS_RDATA_HOLD_EN
   logic [31:0] rdata_buf_q, rdata_buf_d;
   logic        rdata_held_q, rdata_held_d;

   // A blocked stage implies a valid instruction; capture only at the end of its first cycle.
   always_comb begin
      rdata_buf_d  = rdata_buf_q;
      rdata_held_d = rdata_held_q;
      if (ms_allowin) begin
         rdata_held_d = 1'b0;
      end else if (!rdata_held_q) begin
         rdata_held_d = 1'b1;
         rdata_buf_d  = data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_held_q <= 1'b0;
      end else begin
         rdata_held_q <= rdata_held_d;
      end
      rdata_buf_q <= rdata_buf_d;
   end

   assign rdata_use = rdata_held_q ? rdata_buf_q : data_sram_rdata;
`else
   assign rdata_use = data_sram_rdata;
`endif

   always_comb begin
      case (addr_low)
         2'd0:    b = rdata_use[7:0];
         2'd1:    b = rdata_use[15:8];
         2'd2:    b = rdata_use[23:16];
         default: b = rdata_use[31:24];
      endcase
      h = addr_low[1] ? rdata_use[31:16] : rdata_use[15:0];

      load_result = rdata_use;
      if (op_lb) begin
         load_result = {{24{b[7]}}, b};
      end else if (op_lbu) begin
         load_result = {24'd0, b};
      end else if (op_lh) begin
         load_result = {{16{h[15]}}, h};
      end else if (op_lhu) begin
         load_result = {16'd0, h};
      end else if (op_lwl) begin
         case (addr_low)
            2'd0:    load_result = {rdata_use[7:0],  rt_value[23:0]};
            2'd1:    load_result = {rdata_use[15:0], rt_value[15:0]};
            2'd2:    load_result = {rdata_use[23:0], rt_value[7:0]};
            default: load_result = rdata_use;
         endcase
      end else if (op_lwr) begin
         case (addr_low)
            2'd0:    load_result = rdata_use;
            2'd1:    load_result = {rt_value[31:24], rdata_use[31:8]};
            2'd2:    load_result = {rt_value[31:16], rdata_use[31:16]};
            default: load_result = {rt_value[31:8],  rdata_use[31:24]};
         endcase
      end
   end

   assign final_result = res_from_mem ? load_result : alu_result;

   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign ms_fwd_we    = ms_valid_q && gr_we;
   assign ms_fwd_dest  = dest;
   assign ms_fwd_data  = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load cases plus randomized traffic
// compared every cycle against a transaction-level model of the stage.
module tb_mem_stage;

   localparam int ES_W = 111;
   localparam int MS_W = 70;

   logic            clk = 1'b0;
   logic            reset;
   logic            ws_allowin;
   logic            ms_allowin;
   logic            es_to_ms_valid;
   logic [ES_W-1:0] es_to_ms_bus;
   logic [31:0]     data_sram_rdata;
   logic            ms_to_ws_valid;
   logic [MS_W-1:0] ms_to_ws_bus;
   logic            ms_valid;
   logic            ms_fwd_we;
   logic [4:0]      ms_fwd_dest;
   logic [31:0]     ms_fwd_data;

   always #5 clk = ~clk;

   mem_stage #(.ES_TO_MS_BUS_WD(ES_W), .MS_TO_WS_BUS_WD(MS_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_valid        (ms_valid),
      .ms_fwd_we       (ms_fwd_we),
      .ms_fwd_dest     (ms_fwd_dest),
      .ms_fwd_data     (ms_fwd_data)
   );

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endfunction

   // Reference load semantics written arithmetically from the instruction fields.
   function automatic logic [31:0] ref_result(input logic [ES_W-1:0] bus, input logic [31:0] rd);
      int unsigned a;
      logic [31:0] rt, byte_v, half_v;
      rt = bus[110:79];
      a  = int'(bus[77:76]);
      if (!bus[78]) return bus[63:32];
      byte_v = (rd >> (8 * a)) & 32'hFF;
      half_v = bus[77] ? (rd >> 16) : (rd & 32'hFFFF);
      if (bus[75]) return byte_v[7] ? (byte_v | 32'hFFFFFF00) : byte_v;
      if (bus[74]) return byte_v;
      if (bus[73]) return half_v[15] ? (half_v | 32'hFFFF0000) : half_v;
      if (bus[72]) return half_v;
      if (bus[71]) return (rd << (8 * (3 - a))) | (rt & ((32'd1 << (8 * (3 - a))) - 32'd1));
      if (bus[70]) return (rd >> (8 * a)) | (rt & ~(32'hFFFFFFFF >> (8 * a)));
      return rd;
   endfunction

   function automatic logic [ES_W-1:0] mk(input logic [31:0] rt, input logic rfm, input logic [1:0] al,
                                          input logic [5:0] ops, input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {rt, rfm, al, ops, we, dst, alu, pc};
   endfunction

   // Model: one slot holding the instruction and the read word seen in its first cycle.
   logic            m_valid = 1'b0;
   logic            m_first = 1'b0;
   logic [ES_W-1:0] m_bus;
   logic [31:0]     m_data;

   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_first <= 1'b0;
      end else if (!m_valid || ws_allowin) begin
         m_valid <= es_to_ms_valid;
         m_first <= es_to_ms_valid;
         if (es_to_ms_valid) m_bus <= es_to_ms_bus;
      end else if (m_first) begin
         m_data  <= data_sram_rdata;
         m_first <= 1'b0;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] exp_res;
      if (chk_en) begin
         chk("ms_valid", ms_valid, m_valid);
         chk("ms_to_ws_valid", ms_to_ws_valid, m_valid);
         chk("ms_allowin", ms_allowin, !m_valid || ws_allowin);
         chk("ms_fwd_we", ms_fwd_we, m_valid && m_bus[69]);
         if (m_valid) begin
            exp_res = ref_result(m_bus, m_first ? data_sram_rdata : m_data);
            chk("ms_to_ws_bus", ms_to_ws_bus, {m_bus[69:64], exp_res, m_bus[31:0]});
            chk("ms_fwd_dest", ms_fwd_dest, m_bus[68:64]);
            chk("ms_fwd_data", ms_fwd_data, exp_res);
         end
      end
   end

   task automatic issue(input logic [ES_W-1:0] bus, input logic [31:0] rd,
                        input logic [31:0] exp, input string name);
      @(posedge clk); #1;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus;
      ws_allowin     = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = rd;
      @(negedge clk);
      chk({name, "_valid"}, ms_to_ws_valid, 1'b1);
      chk(name, ms_to_ws_bus[63:32], exp);
   endtask

   int departs;
   logic [5:0] ops;

   initial begin
      reset           = 1'b1;
      ws_allowin      = 1'b1;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = '0;
      data_sram_rdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ms_valid", ms_valid, 1'b0);
      chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
      chk("rst_fwd_we", ms_fwd_we, 1'b0);
      chk("rst_allowin", ms_allowin, 1'b1);

      issue(mk(32'h0, 1'b1, 2'd0, 6'b000000, 1'b1, 5'd3, 32'h0, 32'hBFC0_0000), 32'h12345678, 32'h12345678, "lw");
      issue(mk(32'h0, 1'b1, 2'd3, 6'b100000, 1'b1, 5'd4, 32'h0, 32'hBFC0_0004), 32'h80FF7F01, 32'hFFFFFF80, "lb");
      issue(mk(32'h0, 1'b1, 2'd3, 6'b010000, 1'b1, 5'd5, 32'h0, 32'hBFC0_0008), 32'h80FF7F01, 32'h00000080, "lbu");
      issue(mk(32'h0, 1'b1, 2'd2, 6'b001000, 1'b1, 5'd6, 32'h0, 32'hBFC0_000C), 32'h8001AAAA, 32'hFFFF8001, "lh");
      issue(mk(32'h0, 1'b1, 2'd0, 6'b000100, 1'b1, 5'd7, 32'h0, 32'hBFC0_0010), 32'h1234F00F, 32'h0000F00F, "lhu");
      issue(mk(32'hAABBCCDD, 1'b1, 2'd1, 6'b000010, 1'b1, 5'd8, 32'h0, 32'hBFC0_0014), 32'h11223344, 32'h3344CCDD, "lwl1");
      issue(mk(32'hAABBCCDD, 1'b1, 2'd2, 6'b000001, 1'b1, 5'd9, 32'h0, 32'hBFC0_0018), 32'h11223344, 32'hAABB1122, "lwr2");
      issue(mk(32'hAABBCCDD, 1'b1, 2'd0, 6'b000001, 1'b1, 5'd10, 32'h0, 32'hBFC0_001C), 32'h11223344, 32'h11223344, "lwr0");
      issue(mk(32'h0, 1'b0, 2'd1, 6'b100000, 1'b0, 5'd11, 32'hDEADBEEF, 32'hBFC0_0020), 32'h55555555, 32'hDEADBEEF, "alu");
      issue(mk(32'h0, 1'b1, 2'd0, 6'b100001, 1'b1, 5'd12, 32'h0, 32'hBFC0_0024), 32'h000000F0, 32'hFFFFFFF0, "prio");
      issue(mk(32'h0, 1'b1, 2'd3, 6'b001000, 1'b1, 5'd13, 32'h0, 32'hBFC0_0028), 32'h90001234, 32'hFFFF9000, "lh_unal");

      // Back-pressure: three stalled cycles, then a single departure.
      @(posedge clk); #1;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(32'h0, 1'b1, 2'd0, 6'b000000, 1'b1, 5'd14, 32'h0, 32'hBFC0_002C);
      ws_allowin     = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'hCAFEF00D;
      ws_allowin      = 1'b0;
      departs = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("bp_allowin", ms_allowin, 1'b0);
         chk("bp_result", ms_fwd_data, 32'hCAFEF00D);
         if (ms_to_ws_valid && ws_allowin) departs++;
         @(posedge clk); #1;
`ifdef MS_RDATA_HOLD_EN
         data_sram_rdata = 32'h0BAD0BAD ^ 32'(c);
`endif
      end
      ws_allowin = 1'b1;
      @(negedge clk);
      chk("bp_leave_result", ms_fwd_data, 32'hCAFEF00D);
      if (ms_to_ws_valid && ws_allowin) departs++;
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) departs++;
      chk("bp_departs", departs, 1);

      // Reset while stalled drops the held instruction.
      @(posedge clk); #1;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(32'h0, 1'b1, 2'd1, 6'b010000, 1'b1, 5'd15, 32'h0, 32'hBFC0_0030);
      ws_allowin     = 1'b1;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h0000AB00;
      ws_allowin      = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rs_ms_valid", ms_valid, 1'b0);
      chk("rs_fwd_we", ms_fwd_we, 1'b0);
      chk("rs_allowin", ms_allowin, 1'b1);
      issue(mk(32'h0, 1'b1, 2'd1, 6'b010000, 1'b1, 5'd16, 32'h0, 32'hBFC0_0034), 32'h0000AB00, 32'h000000AB, "post_rst");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         reset          = ($urandom_range(0, 199) == 0);
         es_to_ms_valid = ($urandom_range(0, 9) < 7);
         ws_allowin     = ($urandom_range(0, 9) < 6);
         ops = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32'd1 << $urandom_range(0, 6));
         es_to_ms_bus = {$urandom, 1'($urandom), 2'($urandom), ops, 1'($urandom), 5'($urandom),
                         $urandom, $urandom};
         if (!(m_valid && !m_first)) begin
            data_sram_rdata = $urandom;
         end else begin
`ifdef MS_RDATA_HOLD_EN
            data_sram_rdata = $urandom;
`endif
         end
      end
      @(posedge clk); #1;
      reset          = 1'b0;
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b1;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
